// File: rtl/seg7_scan_driver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seg7_scan_driver
// Purpose  : Drives a 4-digit multiplexed common-anode seven-segment display
//            from a 16-bit hex value. A prescaler divides each digit slot
//            into a guard interval (all anodes off, against ghosting) and a
//            drive interval. New values are loaded into a shadow register and
//            moved into the display register only at a frame boundary, so a
//            frame never shows a mix of old and new digits.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            data_in  - hex value, digit 3 = [15:12], digit 0 = [3:0]
//            dp_in    - decimal-point enables, one per digit, active-high
//            blank_in - per-digit force-blank, active-high (live)
//            lz_en    - leading-zero blanking enable (live)
//            load     - strobe that captures data_in/dp_in into the shadow
//            an       - digit anodes, active-low
//            seg      - segments {dp,g,f,e,d,c,b,a}, active-low
//            frame    - one-clock pulse when the shadow is committed
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int CLK_DIV = 25000,
   parameter int GUARD   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   input  logic        lz_en,
   input  logic        load,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frame
);

   localparam int            CW        = $clog2(CLK_DIV);
   localparam logic [CW-1:0] C_CNT_MAX = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] C_GUARD   = CW'(GUARD);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [15:0]   r_shadow_data;
   logic [3:0]    r_shadow_dp;
   logic          r_pending;
   logic [15:0]   r_disp_data;
   logic [3:0]    r_disp_dp;
   logic [3:0]    r_an;
   logic [7:0]    r_seg;
   logic          r_frame;

   logic          w_slot_end;
   logic          w_commit;
   logic [3:0]    w_nib;
   logic          w_lz_blank;
   logic          w_dark;
   logic [6:0]    w_dec;
   logic [3:0]    w_an_nxt;
   logic [7:0]    w_seg_nxt;

   assign w_slot_end = (r_cnt == C_CNT_MAX);
   assign w_commit   = w_slot_end && (r_idx == 2'd3);

   // Scan counters, load/commit path and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt         <= '0;
         r_idx         <= 2'd0;
         r_shadow_data <= 16'h0000;
         r_shadow_dp   <= 4'h0;
         r_pending     <= 1'b0;
         r_disp_data   <= 16'h0000;
         r_disp_dp     <= 4'h0;
         r_an          <= 4'hF;
         r_seg         <= 8'hFF;
         r_frame       <= 1'b0;
      end else begin
         if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         // A load coinciding with a commit wins the pending flag, so the
         // freshly loaded value is committed on the following frame.
         if (load) begin
            r_shadow_data <= data_in;
            r_shadow_dp   <= dp_in;
            r_pending     <= 1'b1;
         end else if (w_commit) begin
            r_pending     <= 1'b0;
         end

         if (w_commit && r_pending) begin
            r_disp_data <= r_shadow_data;
            r_disp_dp   <= r_shadow_dp;
         end
         r_frame <= w_commit && r_pending;

         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
      end
   end

   // Nibble and leading-zero test for the digit currently being scanned.
   always_comb begin
      w_nib      = 4'h0;
      w_lz_blank = 1'b0;
      case (r_idx)
         2'd0: begin
            w_nib      = r_disp_data[3:0];
            w_lz_blank = 1'b0;
         end
         2'd1: begin
            w_nib      = r_disp_data[7:4];
            w_lz_blank = (r_disp_data[15:4] == 12'h000);
         end
         2'd2: begin
            w_nib      = r_disp_data[11:8];
            w_lz_blank = (r_disp_data[15:8] == 8'h00);
         end
         default: begin
            w_nib      = r_disp_data[15:12];
            w_lz_blank = (r_disp_data[15:12] == 4'h0);
         end
      endcase
   end

   // Hex to active-low {g,f,e,d,c,b,a}.
   always_comb begin
      w_dec = 7'h7F;
      case (w_nib)
         4'h0:    w_dec = 7'h40;
         4'h1:    w_dec = 7'h79;
         4'h2:    w_dec = 7'h24;
         4'h3:    w_dec = 7'h30;
         4'h4:    w_dec = 7'h19;
         4'h5:    w_dec = 7'h12;
         4'h6:    w_dec = 7'h02;
         4'h7:    w_dec = 7'h78;
         4'h8:    w_dec = 7'h00;
         4'h9:    w_dec = 7'h10;
         4'hA:    w_dec = 7'h08;
         4'hB:    w_dec = 7'h03;
         4'hC:    w_dec = 7'h46;
         4'hD:    w_dec = 7'h21;
         4'hE:    w_dec = 7'h06;
         default: w_dec = 7'h0E;
      endcase
   end

   // The guard interval keeps all anodes off while the segment lines settle
   // for the next digit, and it separates consecutive anodes so at most one
   // anode is ever low.
   always_comb begin
      w_dark    = (r_cnt < C_GUARD) || blank_in[r_idx] || (lz_en && w_lz_blank);
      w_an_nxt  = 4'hF;
      w_seg_nxt = 8'hFF;
      if (!w_dark) begin
         w_an_nxt  = ~(4'b0001 << r_idx);
         w_seg_nxt = {~r_disp_dp[r_idx], w_dec};
      end
   end

   assign an    = r_an;
   assign seg   = r_seg;
   assign frame = r_frame;

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Output-side counterpart of the board's pushbutton input path: drives the 4-digit multiplexed, common-anode seven-segment display from a 16-bit hex value.
- Contains its own scan prescaler, a digit rotation counter and an anti-ghosting guard interval.
- A double-buffered data register commits new values only at frame boundaries, so the display never tears.
- Sits beside the CPU debug/IO logic and takes register or PC values for display.

Parameters:
- CLK_DIV, 25000: clocks per digit slot; at 50 MHz this is 0.5 ms per digit and 2 ms per frame. Legal range CLK_DIV >= 4.
- GUARD, 16: clocks at the start of each slot with all anodes off. Legal range 1 <= GUARD < CLK_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- data_in  input  16  hex value; digit 3 = [15:12], digit 0 = [3:0]
- dp_in  input  4  decimal-point enables, active-high, one bit per digit
- blank_in  input  4  per-digit force-blank, active-high
- lz_en  input  1  leading-zero blanking enable
- load  input  1  single-cycle strobe; captures data_in and dp_in into the shadow register
- an  output  4  digit anodes, active-low
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
- frame  output  1  one-clock pulse when the shadow register is committed at a frame boundary

Behaviour:
- Clock and reset: one clock domain (clk); rst is asynchronous and active-high.
- Reset values: an=4'hF, seg=8'hFF, frame=0, cnt=0, idx=0, shadow=0, display register=0, pending=0.
- Prescaler: cnt runs 0..CLK_DIV-1, then wraps to 0.
- Digit advance: at the clock where cnt==CLK_DIV-1, idx advances 0->1->2->3->0.
- Load:
  - load=1 writes data_in/dp_in into the shadow register and sets pending.
  - blank_in and lz_en are sampled live; they are not shadowed.
- Commit:
  - Condition: cnt==CLK_DIV-1 and idx==3.
  - If pending, the display register takes the shadow, pending clears, and frame=1 for that one clock.
  - If not pending, frame stays 0.
- load and commit in the same cycle: the commit uses the old shadow, the shadow takes the new data, and pending stays set, so the new data commits next frame.
- Output timing: outputs are registered and are a function of the current (cnt, idx), giving one clock of latency.
  - Guard phase (cnt < GUARD): an=4'hF and seg=8'hFF.
  - Drive phase: an = ~(4'b0001<<idx), and seg = decode(nibble[idx]) with seg[7] = ~dp[idx].
- Digit blanked (an=4'hF, seg=8'hFF for the whole slot) when either holds:
  - blank_in[idx]=1;
  - lz_en=1, idx>0, and every display nibble at positions idx..3 is zero. Digit 0 is never lz-blanked.
- Decode values (bits g..a; dp bit supplied separately):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - With the dp off, the full byte reads C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
- Reset mid-slot: all outputs return immediately to their reset values. After release, scanning restarts at idx 0 with a full guard phase, and any pending load is discarded.
- Invariant: at most one anode bit is low in any cycle, including across every transition.

Test Plan (CLK_DIV=8, GUARD=2):
- Reset then idle:
  - an=F and seg=FF through the first guard phase.
  - First drive phase: an=E and seg=C0 (display register is 0).
- load data_in=16'h12AF, dp_in=0 -> no change until the first commit (cnt==7, idx==3) -> frame=1 for one clock.
  - Next frame's slots show seg F9, A4, 88, 8E on an 7, B, D, E respectively, with a 2-cycle an=F gap before each.
- load twice within one frame (16'h1111, then 16'h2222) -> only 16'h2222 is committed, with a single frame pulse. load coinciding with the commit clock -> the old shadow is shown, the new value appears one frame later, and frame pulses in both frames.
- Leading-zero and decimal point:
  - lz_en=1, value 16'h0050 -> digits 3 and 2 dark (an=F in their slots); digit 1=92, digit 0=C0.
  - Value 16'h0000 -> only digit 0 lit (C0).
  - dp_in=4'b0001 -> digit 0 seg=40.
- blank_in=4'b1010 -> slots 1 and 3 keep an=F for all 8 cycles; slots 0 and 2 drive normally.
- Assert rst during a drive phase of idx=2 -> an=F and seg=FF in the same cycle. After release, the idx=0 slot restarts at cnt=0; a checker over the whole run confirms no cycle has more than one anode bit low.
